// File: rtl/window_frame_ctrl_pkg.sv
// Shared definitions for the window multiply frame sequencer.
// State encoding, bypass coefficient and default geometry.
package window_frame_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_SKIP = 2'd2
   } state_t;

   localparam logic [15:0] COEF_BYPASS_VAL = 16'h7FFF;

   localparam int DEF_ADDR_W   = 11;
   localparam int DEF_COEF_LAT = 1;
   localparam int DEF_MULT_LAT = 3;
   localparam int DEF_CNT_W    = 16;

endpackage

// File: rtl/window_frame_ctrl_vl_delay.sv
// Reset-clearable shift register for the {valid,last} pair.
// Matches the coefficient read plus multiplier pipeline depth.
module window_vl_delay #(
   parameter int DEPTH = 4
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_valid,
   input  logic i_last,
   output logic o_valid,
   output logic o_last
);

   generate
      if (DEPTH == 0) begin : g_pass
         assign o_valid = i_valid;
         assign o_last  = i_last;
      end else begin : g_sr
         logic [DEPTH-1:0] r_v;
         logic [DEPTH-1:0] r_l;

         // Shift valid/last one stage per cycle, cleared by reset.
         always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
               r_v <= '0;
               r_l <= '0;
            end else begin
               r_v[0] <= i_valid;
               r_l[0] <= i_last;
               for (int i = 1; i < DEPTH; i++) begin
                  r_v[i] <= r_v[i-1];
                  r_l[i] <= r_l[i-1];
               end
            end
         end

         assign o_valid = r_v[DEPTH-1];
         assign o_last  = r_l[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/window_frame_ctrl.sv
// Frame sequencer for the window multiply datapath.
// Tracks sample index, enforces frame length, aligns valid/last.
module window_frame_ctrl
   import window_frame_ctrl_pkg::*;
#(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int COEF_LAT = DEF_COEF_LAT,
   parameter int MULT_LAT = DEF_MULT_LAT,
   parameter int CNT_W    = DEF_CNT_W
) (
   input  logic              S_AXIS_ACLK,
   input  logic              S_AXIS_ARESETN,
   input  logic [ADDR_W:0]   frame_len,
   input  logic              disable_window,
   input  logic              force_nowindow,
   input  logic              in_valid,
   input  logic              in_last,
   output logic [ADDR_W-1:0] coef_addr,
   output logic              mult_ce,
   output logic              coef_bypass,
   output logic              out_valid,
   output logic              out_last,
   output logic              err_short,
   output logic              err_long,
   output logic [CNT_W-1:0]  frame_cnt,
   output logic              busy
);

   localparam logic [ADDR_W:0]  LEN_MAX = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0]  ONE     = 1;
   localparam logic [CNT_W-1:0] FC_ONE  = 1;

   state_t            r_state;
   logic [ADDR_W:0]   r_cnt;
   logic [ADDR_W:0]   r_len;
   logic              r_bypass;
   logic              r_disable;
   logic              r_err_short;
   logic              r_err_long;
   logic [CNT_W-1:0]  r_frame_cnt;

   logic [ADDR_W:0]   w_len_in;
   logic              w_at_end;
   logic              w_len_one;
   logic              w_idle;
   logic              w_skip;
   logic              w_int_last;
   logic              w_valid;
   logic              w_last;

   // A programmed length of zero means the full coefficient table.
   assign w_len_in  = (frame_len == '0) ? LEN_MAX : frame_len;
   assign w_len_one = (w_len_in == ONE);
   assign w_at_end  = (r_cnt == r_len - ONE);
   assign w_idle    = (r_state == ST_IDLE);
   assign w_skip    = (r_state == ST_SKIP);

   // Length reached without TLAST: close the frame ourselves.
   assign w_int_last = in_valid & ~in_last &
                       (((r_state == ST_RUN) & w_at_end) |
                        (w_idle & w_len_one));

   assign w_valid = in_valid & ~w_skip;
   assign w_last  = ~w_skip & ((in_valid & in_last) | w_int_last);

   // Frame state, sample counter and frame-boundary latches.
   always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
      if (!S_AXIS_ARESETN) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_len       <= LEN_MAX;
         r_bypass    <= 1'b0;
         r_disable   <= 1'b0;
         r_err_short <= 1'b0;
         r_err_long  <= 1'b0;
         r_frame_cnt <= '0;
      end else begin
         r_err_short <= 1'b0;
         r_err_long  <= 1'b0;
         unique case (r_state)
            ST_IDLE: begin
               r_bypass  <= force_nowindow;
               r_disable <= disable_window;
               if (in_valid) begin
                  r_len <= w_len_in;
                  if (in_last) begin
                     r_frame_cnt <= r_frame_cnt + FC_ONE;
                     r_err_short <= ~w_len_one;
                  end else if (w_len_one) begin
                     r_frame_cnt <= r_frame_cnt + FC_ONE;
                     r_err_long  <= 1'b1;
                     r_state     <= ST_SKIP;
                  end else begin
                     r_cnt   <= ONE;
                     r_state <= ST_RUN;
                  end
               end
            end
            ST_RUN: begin
               if (in_valid) begin
                  if (in_last) begin
                     r_err_short <= ~w_at_end;
                     r_frame_cnt <= r_frame_cnt + FC_ONE;
                     r_cnt       <= '0;
                     r_state     <= ST_IDLE;
                  end else if (w_at_end) begin
                     r_err_long  <= 1'b1;
                     r_frame_cnt <= r_frame_cnt + FC_ONE;
                     r_cnt       <= '0;
                     r_state     <= ST_SKIP;
                  end else begin
                     r_cnt <= r_cnt + ONE;
                  end
               end
            end
            ST_SKIP: begin
               if (in_valid && in_last) begin
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   window_vl_delay #(
      .DEPTH (COEF_LAT + MULT_LAT)
   ) u_vl_delay (
      .i_clk   (S_AXIS_ACLK),
      .i_rst_n (S_AXIS_ARESETN),
      .i_valid (w_valid),
      .i_last  (w_last),
      .o_valid (out_valid),
      .o_last  (out_last)
   );

   // In IDLE the next sample opens a frame, so show the live requests.
   assign coef_bypass = w_idle ? force_nowindow : r_bypass;
   assign mult_ce     = w_idle ? ~disable_window : ~r_disable;
   assign coef_addr   = r_cnt[ADDR_W-1:0];
   assign err_short   = r_err_short;
   assign err_long    = r_err_long;
   assign frame_cnt   = r_frame_cnt;
   assign busy        = ~w_idle;

endmodule

// File: tb/tb_window_frame_ctrl.sv
// Directed bench for window_frame_ctrl.
// Hand-derived expectations checked with immediate assertions.
module tb_window_frame_ctrl;

   logic        clk;
   logic        rst_n;
   logic [11:0] frame_len;
   logic        disable_window;
   logic        force_nowindow;
   logic        in_valid;
   logic        in_last;
   logic [10:0] coef_addr;
   logic        mult_ce;
   logic        coef_bypass;
   logic        out_valid;
   logic        out_last;
   logic        err_short;
   logic        err_long;
   logic [15:0] frame_cnt;
   logic        busy;

   int errors = 0;
   int checks = 0;

   // expected {valid,last} of the last four samples, newest at [0]
   logic [1:0] p [4];

   window_frame_ctrl dut (
      .S_AXIS_ACLK    (clk),
      .S_AXIS_ARESETN (rst_n),
      .frame_len      (frame_len),
      .disable_window (disable_window),
      .force_nowindow (force_nowindow),
      .in_valid       (in_valid),
      .in_last        (in_last),
      .coef_addr      (coef_addr),
      .mult_ce        (mult_ce),
      .coef_bypass    (coef_bypass),
      .out_valid      (out_valid),
      .out_last       (out_last),
      .err_short      (err_short),
      .err_long       (err_long),
      .frame_cnt      (frame_cnt),
      .busy           (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clr_pipe();
      for (int i = 0; i < 4; i++) p[i] = 2'b00;
   endtask

   // One cycle: drive a sample, check the address/bypass it sees,
   // then check delayed outputs and error pulses after the edge.
   task automatic step(input bit v, input bit l, input int ea,
                       input bit eb, input bit ev, input bit el,
                       input bit es, input bit elg);
      in_valid = v;
      in_last  = l;
      #1;
      if (v) chk("coef_addr", 32'(coef_addr), 32'(ea));
      chk("coef_bypass", 32'(coef_bypass), 32'(eb));
      for (int i = 3; i > 0; i--) p[i] = p[i-1];
      p[0] = {ev, el};
      @(posedge clk);
      #1;
      chk("out_valid", 32'(out_valid), 32'(p[3][1]));
      chk("out_last", 32'(out_last), 32'(p[3][0]));
      chk("err_short", 32'(err_short), 32'(es));
      chk("err_long", 32'(err_long), 32'(elg));
   endtask

   task automatic idle(input int n, input bit eb);
      for (int i = 0; i < n; i++) step(0, 0, 0, eb, 0, 0, 0, 0);
   endtask

   initial begin
      rst_n          = 1'b0;
      frame_len      = 12'd8;
      disable_window = 1'b0;
      force_nowindow = 1'b0;
      in_valid       = 1'b0;
      in_last        = 1'b0;
      clr_pipe();
      #22;
      chk("rst_coef_addr", 32'(coef_addr), 0);
      chk("rst_mult_ce", 32'(mult_ce), 1);
      chk("rst_coef_bypass", 32'(coef_bypass), 0);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_last", 32'(out_last), 0);
      chk("rst_err_short", 32'(err_short), 0);
      chk("rst_err_long", 32'(err_long), 0);
      chk("rst_frame_cnt", 32'(frame_cnt), 0);
      chk("rst_busy", 32'(busy), 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // len=8, normal frame
      for (int i = 0; i < 8; i++) begin
         step(1, i == 7, i, 0, 1, i == 7, 0, 0);
         if (i == 0) chk("busy_run", 32'(busy), 1);
      end
      idle(4, 0);
      chk("t1_frame_cnt", 32'(frame_cnt), 1);
      chk("t1_busy", 32'(busy), 0);

      // len=8, TLAST on 5th sample
      for (int i = 0; i < 5; i++)
         step(1, i == 4, i, 0, 1, i == 4, i == 4, 0);
      chk("t2_frame_cnt", 32'(frame_cnt), 2);

      // len=4, 7 samples, TLAST on 7th: tail discarded
      frame_len = 12'd4;
      for (int i = 0; i < 4; i++)
         step(1, 0, i, 0, 1, i == 3, 0, i == 3);
      chk("t3_busy_skip", 32'(busy), 1);
      for (int i = 4; i < 7; i++)
         step(1, i == 6, 0, 0, 0, 0, 0, 0);
      chk("t3_frame_cnt", 32'(frame_cnt), 3);

      // len=8, bypass request raised mid-frame
      frame_len = 12'd8;
      for (int i = 0; i < 8; i++) begin
         if (i == 3) force_nowindow = 1'b1;
         step(1, i == 7, i, 0, 1, i == 7, 0, 0);
      end
      chk("t4_frame_cnt", 32'(frame_cnt), 4);

      // len=4 with gaps; bypass now applies from sample 0
      frame_len = 12'd4;
      step(1, 0, 0, 1, 1, 0, 0, 0);
      force_nowindow = 1'b0;
      step(0, 0, 0, 1, 0, 0, 0, 0);
      step(0, 0, 0, 1, 0, 0, 0, 0);
      step(1, 0, 1, 1, 1, 0, 0, 0);
      step(1, 0, 2, 1, 1, 0, 0, 0);
      step(0, 0, 0, 1, 0, 0, 0, 0);
      step(1, 1, 3, 1, 1, 1, 0, 0);
      idle(4, 0);
      chk("t5_frame_cnt", 32'(frame_cnt), 5);

      // multiplier enable follows the request while idle
      disable_window = 1'b1;
      #1;
      chk("idle_mult_ce_off", 32'(mult_ce), 0);
      disable_window = 1'b0;
      #1;
      chk("idle_mult_ce_on", 32'(mult_ce), 1);

      // reset during sample 2 of a len=8 frame
      frame_len = 12'd8;
      step(1, 0, 0, 0, 1, 0, 0, 0);
      step(1, 0, 1, 0, 1, 0, 0, 0);
      in_valid = 1'b1;
      in_last  = 1'b0;
      #1;
      chk("t6_addr_before", 32'(coef_addr), 2);
      #1;
      rst_n = 1'b0;
      #1;
      chk("t6_coef_addr", 32'(coef_addr), 0);
      chk("t6_out_valid", 32'(out_valid), 0);
      chk("t6_out_last", 32'(out_last), 0);
      chk("t6_frame_cnt", 32'(frame_cnt), 0);
      chk("t6_busy", 32'(busy), 0);
      chk("t6_mult_ce", 32'(mult_ce), 1);
      in_valid = 1'b0;
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      clr_pipe();
      step(1, 1, 0, 0, 1, 1, 1, 0);
      idle(4, 0);
      chk("t6_frame_cnt_after", 32'(frame_cnt), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
